// File: rtl/dbus_io_bank.sv
// rtl/dbus_io_bank.sv - memory-mapped IO register bank for the dBus IO window
// Purpose: byte-enable register bank with UART TX/RX FIFOs, PWM duty registers,
//   synchronised GPIO inputs with change detection and a maskable level irq.
// Ports: clk/resetn (sync active-low); cmd_* dBus command (always accepted);
//   rsp_* registered read response; uart_tx_*/uart_rx_* uart_lite side;
//   gpio_in (async) / gpio_out; pwm_duty flat duty vector; irq.
module dbus_io_bank #(
  parameter int WL          = 32,
  parameter int NUM_PWM     = 4,
  parameter int PWM_WL      = 20,
  parameter int FIFO_DEPTH  = 16,
  parameter int GPIO_IN_WL  = 8,
  parameter int GPIO_OUT_WL = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_valid,
  input  logic                      cmd_wr,
  input  logic [6:0]                cmd_addr,
  input  logic [1:0]                cmd_size,
  input  logic [WL-1:0]             cmd_data,
  output logic                      rsp_valid,
  output logic [WL-1:0]             rsp_data,
  output logic                      rsp_error,
  input  logic                      uart_tx_rdy,
  output logic                      uart_tx_vld,
  output logic [7:0]                uart_tx_data,
  input  logic                      uart_rx_valid,
  input  logic [7:0]                uart_rx_data,
  input  logic [GPIO_IN_WL-1:0]     gpio_in,
  output logic [GPIO_OUT_WL-1:0]    gpio_out,
  output logic [NUM_PWM*PWM_WL-1:0] pwm_duty,
  output logic                      irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [31:0]   ID_VALUE = 32'h10B0_0001;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_HOLD} tx_state_t;

  logic [4:0]             w_idx;
  logic                   w_wr, w_rd;
  logic [3:0]             w_be;
  logic [WL-1:0]          w_wmask;
  logic [WL-1:0]          w_rd_data;
  logic                   w_rd_err;
  logic [23:0]            w_status;
  logic [4:0]             w_irq_stat;
  logic [2:0]             w_w1c;
  logic                   w_unused_bits;

  logic [GPIO_OUT_WL-1:0] r_gpio_out;
  logic [4:0]             r_irq_en;
  logic [PWM_WL-1:0]      r_pwm [NUM_PWM];
  logic                   r_rx_ovf, r_tx_ovf, r_gpio_chg, r_irq;
  logic [GPIO_IN_WL-1:0]  r_gpio_s1, r_gpio_s2, r_gpio_d;

  logic [7:0]             r_rx_mem [FIFO_DEPTH];
  logic [7:0]             r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;
  logic [CW-1:0]          r_rx_count, r_tx_count;
  logic                   w_rx_nonempty, w_rx_full, w_tx_empty, w_tx_full;
  logic                   w_rx_push, w_rx_pop, w_rx_ovf_set;
  logic                   w_tx_req, w_tx_push, w_tx_pop, w_tx_ovf_set;
  logic [7:0]             r_tx_byte;
  tx_state_t              r_tx_state, w_tx_state_nxt;

  assign w_idx = cmd_addr[6:2];
  assign w_wr  = cmd_valid & cmd_wr;
  assign w_rd  = cmd_valid & ~cmd_wr;

  always_comb begin
    case (cmd_size)
      2'd0:    w_be = 4'b0001 << cmd_addr[1:0];
      2'd1:    w_be = 4'b0011 << cmd_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  for (genvar g = 0; g < WL; g++) begin : g_wmask
    assign w_wmask[g] = w_be[g/8];
  end

  // Registers narrower than the bus only consume their low slices.
  assign w_unused_bits = ^{cmd_data, w_wmask};

  assign w_rx_nonempty = (r_rx_count != '0);
  assign w_rx_full     = (r_rx_count == FULL_CNT);
  assign w_tx_empty    = (r_tx_count == '0);
  assign w_tx_full     = (r_tx_count == FULL_CNT);

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_rx_pop     = w_rd && (w_idx == 5'd3) && w_rx_nonempty;
  assign w_rx_push    = uart_rx_valid && (!w_rx_full || w_rx_pop);
  assign w_rx_ovf_set = uart_rx_valid && w_rx_full && !w_rx_pop;
  assign w_tx_req     = w_wr && (w_idx == 5'd2) && w_be[0];
  assign w_tx_push    = w_tx_req && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf_set = w_tx_req && w_tx_full && !w_tx_pop;

  assign w_status   = {8'(r_rx_count), 8'(r_tx_count), 4'b0000,
                       w_rx_full, ~w_rx_nonempty, w_tx_full, w_tx_empty};
  assign w_irq_stat = {r_gpio_chg, r_tx_ovf, r_rx_ovf, w_tx_empty, w_rx_nonempty};
  assign w_w1c      = (w_wr && (w_idx == 5'd7)) ? (cmd_data[4:2] & w_wmask[4:2]) : 3'b000;

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_idx)
      5'd0: w_rd_data = WL'(ID_VALUE);
      5'd1: w_rd_data = WL'(w_status);
      5'd2: w_rd_data = '0;
      5'd3: begin
        if (w_rx_nonempty) begin
          w_rd_data         = WL'(r_rx_mem[r_rx_rd]);
          w_rd_data[WL-1]   = 1'b1;
        end
      end
      5'd4: w_rd_data = WL'(r_gpio_out);
      5'd5: w_rd_data = WL'(r_gpio_s2);
      5'd6: w_rd_data = WL'(r_irq_en);
      5'd7: w_rd_data = WL'(w_irq_stat);
      default: begin
        w_rd_err = 1'b1;
        for (int k = 0; k < NUM_PWM; k++) begin
          if (w_idx == 5'(8 + k)) begin
            w_rd_data = WL'(r_pwm[k]);
            w_rd_err  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      r_gpio_out <= '0;
      r_irq_en   <= '0;
      for (int k = 0; k < NUM_PWM; k++) r_pwm[k] <= '0;
      r_rx_ovf   <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_gpio_chg <= 1'b0;
      r_irq      <= 1'b0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
      r_gpio_d   <= '0;
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
      r_tx_byte  <= '0;
    end else begin
      rsp_valid <= w_rd;
      rsp_data  <= w_rd ? w_rd_data : '0;
      rsp_error <= w_rd & w_rd_err;

      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
      r_gpio_d  <= r_gpio_s2;

      if (w_wr && (w_idx == 5'd4))
        r_gpio_out <= (r_gpio_out & ~w_wmask[GPIO_OUT_WL-1:0]) |
                      (cmd_data[GPIO_OUT_WL-1:0] & w_wmask[GPIO_OUT_WL-1:0]);
      if (w_wr && (w_idx == 5'd6))
        r_irq_en <= (r_irq_en & ~w_wmask[4:0]) | (cmd_data[4:0] & w_wmask[4:0]);
      for (int k = 0; k < NUM_PWM; k++) begin
        if (w_wr && (w_idx == 5'(8 + k)))
          r_pwm[k] <= (r_pwm[k] & ~w_wmask[PWM_WL-1:0]) |
                      (cmd_data[PWM_WL-1:0] & w_wmask[PWM_WL-1:0]);
      end

      // Set terms are OR-ed after the clear so a same-cycle event survives.
      r_rx_ovf   <= (r_rx_ovf & ~w_w1c[0]) | w_rx_ovf_set;
      r_tx_ovf   <= (r_tx_ovf & ~w_w1c[1]) | w_tx_ovf_set;
      r_gpio_chg <= (r_gpio_chg & ~w_w1c[2]) | (r_gpio_s2 != r_gpio_d);
      r_irq      <= |(w_irq_stat & r_irq_en);

      if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CW'(1);
        2'b01:   r_rx_count <= r_rx_count - CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase

      if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
      if (w_tx_pop) begin
        r_tx_rd   <= r_tx_rd + AW'(1);
        r_tx_byte <= r_tx_mem[r_tx_rd];
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CW'(1);
        2'b01:   r_tx_count <= r_tx_count - CW'(1);
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= uart_rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= cmd_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_tx_state <= S_IDLE;
    else         r_tx_state <= w_tx_state_nxt;
  end

  // HOLD gives uart_lite a cycle to drop uart_tx_rdy before the next strobe.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_tx_empty && uart_tx_rdy) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = S_STROBE;
        end
      end
      S_STROBE: w_tx_state_nxt = S_HOLD;
      S_HOLD:   w_tx_state_nxt = S_IDLE;
      default:  w_tx_state_nxt = S_IDLE;
    endcase
  end

  assign uart_tx_vld  = (r_tx_state == S_STROBE);
  assign uart_tx_data = r_tx_byte;
  assign gpio_out     = r_gpio_out;
  assign irq          = r_irq;

  for (genvar k = 0; k < NUM_PWM; k++) begin : g_pwm
    assign pwm_duty[k*PWM_WL +: PWM_WL] = r_pwm[k];
  end

endmodule

// File: doc/dbus_io_bank.md
Name: dbus_io_bank

Overview:
Parametrised memory-mapped IO register bank on the VexRiscv dBus IO window (address bit 31 set). It replaces the flat per-word IO register array with:
- byte-enable writes;
- a read-side-effect RX FIFO and a TX FIFO in front of uart_lite;
- N PWM duty registers;
- synchronised GPIO inputs with change detection;
- a maskable interrupt controller.

Parameters:
WL, 32, data word width.
NUM_PWM, 4, number of PWM duty registers (1..16).
PWM_WL, 20, duty-cycle width driven per PWM channel.
FIFO_DEPTH, 16, TX and RX FIFO depth; power of 2, minimum 2.
GPIO_IN_WL, 8, synchronised input bits (buttons and switches).
GPIO_OUT_WL, 4, output bits (LEDs).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
cmd_valid  in  1  dBus command valid, qualified by the IO select
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  7  byte address bits [6:0]
cmd_size  in  2  0 = byte, 1 = half, 2 = word
cmd_data  in  WL  write data, byte-lane aligned
rsp_valid  out  1  read data valid
rsp_data  out  WL  read data
rsp_error  out  1  unmapped access, valid together with rsp_valid
uart_tx_rdy  in  1  uart_lite ready
uart_tx_vld  out  1  uart_lite send strobe
uart_tx_data  out  8  byte to send
uart_rx_valid  in  1  received byte strobe
uart_rx_data  in  8  received byte
gpio_in  in  GPIO_IN_WL  asynchronous inputs
gpio_out  out  GPIO_OUT_WL  registered outputs
pwm_duty  out  NUM_PWM*PWM_WL  flat duty vector; channel k occupies [k*PWM_WL +: PWM_WL]
irq  out  1  level interrupt

Behaviour:
- Reset (resetn = 0 at a clk edge) has priority over all other activity:
  - all registers 0, both FIFOs empty, sticky flags cleared;
  - outputs uart_tx_vld, rsp_valid, rsp_error, irq, gpio_out, pwm_duty all 0.
  - A reset during an active TX strobe discards the FIFO contents and any in-flight command.
- cmd_ready is implicitly always 1.
- Writes take effect at the clk edge of the command.
- Reads: rsp_valid = 1 exactly one cycle after a read command; rsp_data and rsp_error are valid in that cycle. Writes produce no response.
- Byte enables:
  - size 0: 0001 << addr[1:0];
  - size 1: 0011 << addr[1:0];
  - otherwise: 1111.
  - Applied only to RW registers. TX_DATA pushes cmd_data[7:0] on any write that enables lane 0.
- Register map (word index = addr[6:2]):
  - 0 ID: RO, 0x10B0_0001.
  - 1 STATUS: RO, {rx_count[23:16], tx_count[15:8], 4'b0, rx_full, rx_empty, tx_full, tx_empty}. Counts are 0..FIFO_DEPTH.
  - 2 TX_DATA: WO; reads return 0. Write pushes a byte. When the FIFO is full the byte is dropped and IRQ_STAT[3] is set.
  - 3 RX_DATA: RO. Read pops a byte and returns {1'b1, 23'b0, byte}. When empty, returns 0 with no pop.
  - 4 GPIO_OUT: RW, low GPIO_OUT_WL bits.
  - 5 GPIO_IN: RO, 2-flop synchronised value.
  - 6 IRQ_EN: RW, bits [4:0].
  - 7 IRQ_STAT: read returns status; write-1-to-clear on the sticky bits [4:2].
  - 8 .. 8+NUM_PWM-1 PWM_DUTY[k]: RW, low PWM_WL bits. Upper bits read as 0.
  - Any other index: reads return 0 with rsp_error = 1; writes are ignored.
- IRQ_STAT bits:
  - [0] rx_nonempty, level;
  - [1] tx_empty, level;
  - [2] rx_overflow, sticky;
  - [3] tx_overflow, sticky;
  - [4] gpio_change, sticky; set when the synchronised value differs from its one-cycle-delayed copy.
  - irq = |(IRQ_STAT & IRQ_EN), registered (1-cycle latency).
  - If a set and a W1C clear hit the same cycle, set wins.
- RX FIFO:
  - uart_rx_valid pushes uart_rx_data.
  - Push and CPU pop in the same cycle: both happen and the count is unchanged. This also holds when full.
  - Push when full with no pop: byte dropped, IRQ_STAT[2] set. Existing contents are never overwritten.
- TX drain state machine:
  - States: IDLE, STROBE, HOLD.
  - IDLE -> STROBE when the TX FIFO is non-empty and uart_tx_rdy = 1. The head byte is popped and driven on uart_tx_data.
  - STROBE: uart_tx_vld = 1 for exactly 1 cycle, then go to HOLD.
  - HOLD: 1 cycle, letting uart_tx_rdy fall, then go to IDLE.
  - uart_tx_data holds its value until the next strobe.
  - CPU push and drain pop in the same cycle: both happen, count unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The full/empty decision uses a separate count register.

Test Plan:
- Reset and ID: assert resetn = 0 for 2 cycles, then read index 0 -> rsp_valid the cycle after the command, rsp_data = 0x10B0_0001; STATUS = 0x0000_0005.
- Byte-enable write: write word 0xAABBCCDD to PWM_DUTY[1], then a size-0 write of 0x0000_EE00 at addr offset +1 -> PWM_DUTY[1] reads 0x000B_EEDD (PWM_WL = 20); pwm_duty[39:20] = 0xBEEDD.
- TX path: push 0x41, 0x42 with uart_tx_rdy held at 1 -> two single-cycle uart_tx_vld pulses carrying 0x41 then 0x42, at least 2 cycles apart; tx_empty returns to 1.
- RX overflow: inject 17 uart_rx_valid bytes 0x00..0x10 with no reads -> STATUS.rx_count = 16 and IRQ_STAT[2] = 1; 16 reads return 0x8000_0000..0x8000_000F; the 17th read returns 0.
- IRQ: IRQ_EN = 0x10, toggle gpio_in[0] -> irq = 1 within 4 cycles; write IRQ_STAT = 0x10 -> irq = 0 on the following cycle.
- Unmapped: read index 20 -> rsp_data = 0, rsp_error = 1; write to index 20 -> no register changes.
